// File: rtl/instr_mem_loader_if.sv
// Load/fetch bus of the fetch-stage instruction memory.
// master = PC logic / boot loader side, slave = the memory.
interface instr_mem_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 256
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic                  load_start;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;
  logic                  load_ready;
  logic                  loading;
  logic [LW-1:0]         prog_len;
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  stall;
  logic [DATA_WIDTH-1:0] instr;
  logic                  instr_valid;
  logic                  fetch_fault;

  modport master (
    output load_start, load_valid, load_data, load_last, fetch_req, fetch_addr, stall,
    input  load_ready, loading, prog_len, instr, instr_valid, fetch_fault
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last, fetch_req, fetch_addr, stall,
    output load_ready, loading, prog_len, instr, instr_valid, fetch_fault
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Loadable instruction memory: streamed program load, registered fetch with
// stall hold, and NOP substitution for fetches beyond the loaded program.
module instr_mem_loader #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 256,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input logic                clock,
  input logic                reset,
  instr_mem_loader_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (ADDR_WIDTH > LW) ? ADDR_WIDTH : LW;

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  state_t                r_state;
  logic [AW-1:0]         r_wr_ptr;
  logic [LW-1:0]         r_prog_len;
  logic                  r_load_ready;
  logic                  r_loading;
  logic [DATA_WIDTH-1:0] r_instr;
  logic                  r_instr_valid;
  logic                  r_fetch_fault;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_xfer;
  logic                  w_in_range;
  logic                  w_full;
  logic [AW-1:0]         w_rd_idx;

  assign w_xfer     = (r_state == LOAD) && bus.load_valid;
  // Full-width unsigned compare so any nonzero upper address bit faults.
  assign w_in_range = CW'(bus.fetch_addr) < CW'(r_prog_len);
  assign w_full     = r_prog_len == LW'(DEPTH - 1);
  assign w_rd_idx   = bus.fetch_addr[AW-1:0];

  // Array is never reset; stale words stay unreachable via prog_len.
  always_ff @(posedge clock) begin
    if (w_xfer) r_mem[r_wr_ptr] <= bus.load_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_wr_ptr      <= '0;
      r_prog_len    <= '0;
      r_load_ready  <= 1'b0;
      r_loading     <= 1'b0;
      r_instr       <= NOP_WORD;
      r_instr_valid <= 1'b0;
      r_fetch_fault <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_instr_valid <= 1'b0;
          r_fetch_fault <= 1'b0;
          if (bus.load_start) begin
            r_state      <= LOAD;
            r_wr_ptr     <= '0;
            r_prog_len   <= '0;
            r_load_ready <= 1'b1;
            r_loading    <= 1'b1;
          end
        end
        LOAD: begin
          r_instr_valid <= 1'b0;
          r_fetch_fault <= 1'b0;
          if (w_xfer) begin
            r_wr_ptr   <= r_wr_ptr + AW'(1);
            r_prog_len <= r_prog_len + LW'(1);
            if (bus.load_last || w_full) begin
              r_state      <= READY;
              r_load_ready <= 1'b0;
              r_loading    <= 1'b0;
            end
          end
        end
        READY: begin
          // Reload wins over both stall and a concurrent fetch.
          if (bus.load_start) begin
            r_state       <= LOAD;
            r_wr_ptr      <= '0;
            r_prog_len    <= '0;
            r_load_ready  <= 1'b1;
            r_loading     <= 1'b1;
            r_instr_valid <= 1'b0;
            r_fetch_fault <= 1'b0;
          end else if (!bus.stall) begin
            if (bus.fetch_req) begin
              r_instr_valid <= 1'b1;
              if (w_in_range) begin
                r_instr       <= r_mem[w_rd_idx];
                r_fetch_fault <= 1'b0;
              end else begin
                r_instr       <= NOP_WORD;
                r_fetch_fault <= 1'b1;
              end
            end else begin
              r_instr_valid <= 1'b0;
              r_fetch_fault <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.load_ready  = r_load_ready;
  assign bus.loading     = r_loading;
  assign bus.prog_len    = r_prog_len;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_instr_valid;
  assign bus.fetch_fault = r_fetch_fault;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a DEPTH=256 instance for load/fetch/
// stall/reload/reset, and a DEPTH=4 instance for the overflow case.
module tb_instr_mem_loader;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  instr_mem_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(256)) bus ();
  instr_mem_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4))   bus4 ();

  instr_mem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(256), .NOP_WORD(NOP))
    u_dut (.clock(clock), .reset(reset), .bus(bus));
  instr_mem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4), .NOP_WORD(32'h0))
    u_dut4 (.clock(clock), .reset(reset), .bus(bus4));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch_chk(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_instr, input logic exp_fault);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = addr;
    step();
    chk({tag, ".instr"}, 64'(bus.instr), 64'(exp_instr));
    chk({tag, ".valid"}, 64'(bus.instr_valid), 64'd1);
    chk({tag, ".fault"}, 64'(bus.fetch_fault), 64'(exp_fault));
  endtask

  initial begin
    logic [31:0] prog [3];
    logic [31:0] d4 [6];
    prog[0] = 32'h0C00_0006; prog[1] = 32'h0C00_000A; prog[2] = 32'h0000_0000;
    d4[0] = 32'hA0; d4[1] = 32'hA1; d4[2] = 32'hA2;
    d4[3] = 32'hA3; d4[4] = 32'hA4; d4[5] = 32'hA5;

    bus.load_start = 0; bus.load_valid = 0; bus.load_data = 0; bus.load_last = 0;
    bus.fetch_req = 0; bus.fetch_addr = 0; bus.stall = 0;
    bus4.load_start = 0; bus4.load_valid = 0; bus4.load_data = 0; bus4.load_last = 0;
    bus4.fetch_req = 0; bus4.fetch_addr = 0; bus4.stall = 0;

    step(); step();
    chk("rst.load_ready", 64'(bus.load_ready), 64'd0);
    chk("rst.loading", 64'(bus.loading), 64'd0);
    chk("rst.valid", 64'(bus.instr_valid), 64'd0);
    chk("rst.fault", 64'(bus.fetch_fault), 64'd0);
    chk("rst.instr", 64'(bus.instr), 64'(NOP));
    chk("rst.prog_len", 64'(bus.prog_len), 64'd0);
    reset = 0;

    // Three-word load with load_last on the third.
    bus.load_start = 1; step(); bus.load_start = 0;
    chk("load.loading", 64'(bus.loading), 64'd1);
    chk("load.ready", 64'(bus.load_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      bus.load_valid = 1; bus.load_data = prog[i]; bus.load_last = (i == 2);
      step();
    end
    bus.load_valid = 0; bus.load_last = 0;
    chk("load.prog_len", 64'(bus.prog_len), 64'd3);
    chk("load.done_loading", 64'(bus.loading), 64'd0);
    chk("load.done_ready", 64'(bus.load_ready), 64'd0);

    fetch_chk("f0", 32'd0, prog[0], 1'b0);
    fetch_chk("f1", 32'd1, prog[1], 1'b0);
    fetch_chk("f2", 32'd2, prog[2], 1'b0);
    fetch_chk("oor3", 32'd3, NOP, 1'b1);
    fetch_chk("oor_hi", 32'h8000_0000, NOP, 1'b1);

    // Stall holds the response while fetch_req/address keep moving.
    fetch_chk("pre_stall", 32'd1, prog[1], 1'b0);
    bus.stall = 1;
    for (int i = 0; i < 4; i++) begin
      bus.fetch_addr = (i % 2 == 0) ? 32'd0 : 32'd7;
      step();
      chk("stall.instr", 64'(bus.instr), 64'(prog[1]));
      chk("stall.valid", 64'(bus.instr_valid), 64'd1);
    end
    bus.stall = 0;
    fetch_chk("post_stall", 32'd0, prog[0], 1'b0);

    bus.fetch_req = 0; step();
    chk("noreq.valid", 64'(bus.instr_valid), 64'd0);
    chk("noreq.instr_hold", 64'(bus.instr), 64'(prog[0]));

    // Reload with a concurrent fetch: reload wins.
    bus.load_start = 1; bus.fetch_req = 1; bus.fetch_addr = 1; step();
    bus.load_start = 0; bus.fetch_req = 0;
    chk("reload.valid", 64'(bus.instr_valid), 64'd0);
    chk("reload.loading", 64'(bus.loading), 64'd1);
    chk("reload.prog_len", 64'(bus.prog_len), 64'd0);
    bus.load_valid = 1; bus.load_data = 32'h1111_0000; step();
    bus.load_data = 32'h2222_0000; bus.load_last = 1; step();
    bus.load_valid = 0; bus.load_last = 0;
    chk("reload.len2", 64'(bus.prog_len), 64'd2);
    fetch_chk("reload.f0", 32'd0, 32'h1111_0000, 1'b0);
    fetch_chk("reload.f2", 32'd2, NOP, 1'b1);
    bus.fetch_req = 0;

    // Asynchronous reset after 2 of 5 load words.
    bus.load_start = 1; step(); bus.load_start = 0;
    bus.load_valid = 1; bus.load_data = 32'h55; step();
    bus.load_data = 32'h66; step();
    bus.load_data = 32'h77;
    #2 reset = 1; #1;
    chk("midrst.loading", 64'(bus.loading), 64'd0);
    chk("midrst.prog_len", 64'(bus.prog_len), 64'd0);
    chk("midrst.valid", 64'(bus.instr_valid), 64'd0);
    chk("midrst.load_ready", 64'(bus.load_ready), 64'd0);
    bus.load_valid = 0;
    #3 reset = 0;
    bus.fetch_req = 1; bus.fetch_addr = 0; step(); step();
    chk("idle.valid", 64'(bus.instr_valid), 64'd0);
    chk("idle.instr", 64'(bus.instr), 64'(NOP));
    bus.fetch_req = 0;

    // Reset while stalled on a valid response.
    bus.load_start = 1; step(); bus.load_start = 0;
    bus.load_valid = 1; bus.load_last = 1; bus.load_data = 32'hCAFE; step();
    bus.load_valid = 0; bus.load_last = 0;
    fetch_chk("pre_rst_stall", 32'd0, 32'hCAFE, 1'b0);
    bus.stall = 1; step();
    chk("stall_rst.pre", 64'(bus.instr_valid), 64'd1);
    #2 reset = 1; #1;
    chk("stall_rst.valid", 64'(bus.instr_valid), 64'd0);
    chk("stall_rst.instr", 64'(bus.instr), 64'(NOP));
    bus.stall = 0; bus.fetch_req = 0;
    #3 reset = 0;

    // DEPTH=4 overflow: six words, no load_last.
    bus4.load_start = 1; step(); bus4.load_start = 0;
    for (int i = 0; i < 6; i++) begin
      bus4.load_valid = 1; bus4.load_data = d4[i];
      step();
      if (i == 2) chk("d4.ready_w3", 64'(bus4.load_ready), 64'd1);
      if (i == 3) chk("d4.ready_w4", 64'(bus4.load_ready), 64'd0);
    end
    bus4.load_valid = 0;
    chk("d4.prog_len", 64'(bus4.prog_len), 64'd4);
    chk("d4.loading", 64'(bus4.loading), 64'd0);
    for (int i = 0; i < 5; i++) begin
      bus4.fetch_req = 1; bus4.fetch_addr = 32'(i); step();
      chk("d4.instr", 64'(bus4.instr), (i < 4) ? 64'(d4[i]) : 64'd0);
      chk("d4.fault", 64'(bus4.fetch_fault), (i < 4) ? 64'd0 : 64'd1);
    end
    bus4.fetch_req = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Parametrised, loadable instruction memory for the fetch stage. It replaces a fixed, hand-initialised instruction array with three things: a streaming program-load port, a registered fetch port with stall hold, and out-of-range fault detection. It sits between the PC logic (fetch_addr, stall) and the instruction register / decode stage. The program is streamed in after reset by a testbench or boot loader.

## Interface
Parameters:
- DATA_WIDTH, 32: instruction word width.
- ADDR_WIDTH, 32: fetch address width; addresses are word addresses.
- DEPTH, 256: number of words; must be a power of two, 2..65536.
- NOP_WORD, 0: word returned on a faulting fetch.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_start  in  1  begins a program load; sampled in IDLE or READY.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  DATA_WIDTH  instruction word to store.
- load_last  in  1  qualifies the final word of the program when load_valid=1.
- load_ready  out  1  high in LOAD; a word transfers when load_valid && load_ready.
- loading  out  1  high while in LOAD.
- prog_len  out  clog2(DEPTH)+1  number of words in the current program.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_WIDTH  word address to fetch.
- stall  in  1  freezes the fetch output registers.
- instr  out  DATA_WIDTH  fetched instruction.
- instr_valid  out  1  instr holds a response.
- fetch_fault  out  1  the current response was out of range; instr = NOP_WORD.

## Operation
FSM states: IDLE, LOAD, READY. Reset enters IDLE.

Reset values:
- load_ready, loading, instr_valid, fetch_fault = 0.
- instr = NOP_WORD, prog_len = 0, write pointer wr_ptr = 0.
- Array contents are not cleared.

IDLE:
- load_start -> LOAD.
- Fetch requests are ignored; instr_valid stays 0.

LOAD:
- On entry: wr_ptr = 0 and prog_len = 0.
- Each transfer writes mem[wr_ptr] = load_data, then wr_ptr++ and prog_len++.
- A transfer with load_last=1 -> READY.
- The DEPTH-th transfer -> READY, with or without load_last. Further words are not accepted.
- load_start is ignored while in LOAD.
- fetch_req is ignored; instr_valid is forced to 0.

READY (one fetch per cycle):
- stall=1: instr, instr_valid and fetch_fault hold their values, whatever fetch_req is.
- stall=0, fetch_req=1, fetch_addr < prog_len: instr = mem[fetch_addr], instr_valid=1, fetch_fault=0.
- stall=0, fetch_req=1, fetch_addr >= prog_len (this covers any nonzero upper address bits): instr = NOP_WORD, instr_valid=1, fetch_fault=1.
- stall=0, fetch_req=0: instr_valid=0, fetch_fault=0, instr holds.
- load_start=1 -> LOAD (reload). It takes priority over a simultaneous fetch_req and over stall: that fetch is dropped and instr_valid=0 next cycle.

Comparisons and widths:
- fetch_addr is compared as unsigned across its full ADDR_WIDTH against zero-extended prog_len.
- The array is indexed with the low clog2(DEPTH) bits of the address only after the range check passes.

## Timing
- Fetch latency is 1 cycle: a request at edge N gives a response visible after edge N, valid during cycle N+1.
- Back-to-back fetches give one response per cycle.
- Load: one word per cycle at full rate.
  - The state is READY in the cycle after the last transfer.
  - A fetch issued in that first READY cycle returns the newly loaded data.
- Minimum program-load time is prog_len + 1 cycles, counted from load_start to the first accepted fetch.
- The load write and the fetch read never occur in the same cycle; no read-during-write case exists.
- Reset mid-load:
  - Outputs return to their reset values immediately (asynchronous), with prog_len = 0.
  - Partially written words are unreachable until the next load.
- Reset while stalled clears instr_valid immediately.

## Test plan
- Load 3 words 0x0C000006, 0x0C00000A, 0x00000000 with load_last on the 3rd -> prog_len=3, READY next cycle. Fetch addresses 0,1,2 back-to-back -> those words on 3 consecutive cycles, instr_valid=1, fetch_fault=0.
- With prog_len=3: fetch address 3, then 0x8000_0000 -> instr=NOP_WORD with fetch_fault=1 on both responses, instr_valid=1.
- Fetch address 1, then assert stall for 4 cycles while fetch_req=1 and the address changes -> instr stays the word at address 1 and instr_valid stays 1 throughout. On release, the new address responds 1 cycle later.
- DEPTH=4: stream 6 words with no load_last -> load_ready drops after the 4th word, prog_len=4, and words 5 and 6 are not written.
- In READY, assert load_start together with fetch_req -> instr_valid=0 next cycle, loading=1, prog_len=0. Reload 2 words -> fetch address 2 faults.
- Assert reset after 2 of 5 load words -> loading=0, prog_len=0 and instr_valid=0 immediately. Fetch address 0 in IDLE -> no response.
